btn_debounce: RTL

// - Conditions raw board inputs (reset_btn, manual_clk_sw, pulse_clk_btn) before clk_rst_gen and the CPU top see them.
// - Per channel: metastability synchroniser, debounce counter, registered level output, one-cycle rise/fall strobes.
// - Runs on the free-running board clock, upstream of clk_rst_gen; never clocked by the CPU clock.

---
 rtl/btn_debounce_pkg.sv | 27 ++
 rtl/btn_debounce_chan.sv | 153 +++++++++++++++
 rtl/btn_debounce.sv | 42 ++++
 3 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types, default parameter values and sizing helpers for the button debouncer.
// Optional auto-repeat is selected with the BTN_DEBOUNCE_AUTOREPEAT_EN macro.
package btn_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } btn_state_e;

   localparam int DEF_NUM_IN          = 3;
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 10000;
   localparam int DEF_REPEAT_DELAY    = 500000;
   localparam int DEF_REPEAT_PERIOD   = 100000;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One channel: synchroniser, debounce FSM, registered level and strobes; level moves SYNC_STAGES+DEBOUNCE_CYCLES clocks after a clean edge.
// No backpressure: strobes are single-cycle and never held; auto-repeat on btn_rise when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module btn_debounce_chan
   import btn_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   btn_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   s;
   logic                   rpt_fire;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
   assign s      = sync_q[SYNC_STAGES-1];

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [RPT_W-1:0] RPT_ONE        = RPT_W'(1);
   localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   // Set once the first repeat has fired; later repeats use the shorter period.
   logic             rpt_arm_q, rpt_arm_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rpt_cnt_q <= '0;
         rpt_arm_q <= 1'b0;
      end else begin
         rpt_cnt_q <= rpt_cnt_d;
         rpt_arm_q <= rpt_arm_d;
      end
   end

   always_comb begin
      rpt_cnt_d = '0;
      rpt_arm_d = 1'b0;
      rpt_fire  = 1'b0;
      if (state_q == IDLE_HIGH && s) begin
         rpt_arm_d = rpt_arm_q;
         if (rpt_cnt_q == (rpt_arm_q ? RPT_PER_LAST : RPT_DELAY_LAST)) begin
            rpt_fire  = 1'b1;
            rpt_arm_d = 1'b1;
            rpt_cnt_d = '0;
         end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_ONE;
         end
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         IDLE_LOW: begin
            if (s) begin
               state_d = WAIT_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (!s) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!s) begin
               state_d = WAIT_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               rise_d = rpt_fire;
            end
         end
         WAIT_LOW: begin
            if (s) begin
               state_d = IDLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LOW;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   assign btn_level = level_q;
   assign btn_rise  = rise_q;
   assign btn_fall  = fall_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces NUM_IN raw board inputs; latency SYNC_STAGES+DEBOUNCE_CYCLES clocks from clean edge to level/strobe.
// No backpressure; BTN_DEBOUNCE_AUTOREPEAT_EN adds held-button auto-repeat on btn_rise.
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int NUM_IN          = DEF_NUM_IN,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NUM_IN-1:0] btn_raw,
   output logic [NUM_IN-1:0] btn_level,
   output logic [NUM_IN-1:0] btn_rise,
   output logic [NUM_IN-1:0] btn_fall
);

   for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
      btn_debounce_chan #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .btn_raw   (btn_raw[i]),
         .btn_level (btn_level[i]),
         .btn_rise  (btn_rise[i]),
         .btn_fall  (btn_fall[i])
      );
   end

endmodule
